// File: rtl/elementwise_pkg.sv
// Shared definitions for the serial/parallel bridge around the 4-lane elementwise multiplier.
package elementwise_pkg;

  localparam int LANES = 4;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Lane index successor; the 2-bit index wraps 3 -> 0 by construction.
  function automatic logic [1:0] next_idx(input logic [1:0] idx);
    return idx + 2'd1;
  endfunction

endpackage

// File: rtl/elementwise_result_serializer.sv
// Captures the 4 parallel products on a load strobe and streams them out one per handshake.
module elementwise_result_serializer
  import elementwise_pkg::*;
#(
  parameter int N = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [2*N-1:0]   result [0:LANES-1],
  input  logic             out_ready,
  output logic             out_valid,
  output logic             out_last,
  output logic [2*N-1:0]   out_data,
  output logic             done
);

  localparam int PW = 2 * N;
  typedef logic [PW-1:0] prod_t;

  prod_t      res_buf [0:LANES-1];
  logic [1:0] idx;
  logic       fire;

  assign fire = out_valid & out_ready;
  assign done = fire & (idx == 2'd3);

  // Capture buffer, drain index and registered output stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LANES; i++) res_buf[i] <= '0;
      idx       <= 2'd0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
    end else if (load) begin
      for (int i = 0; i < LANES; i++) res_buf[i] <= result[i];
      idx       <= 2'd0;
      out_valid <= 1'b1;
      out_last  <= 1'b0;
      out_data  <= result[0];
    end else if (done) begin
      idx       <= 2'd0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
    end else if (fire) begin
      idx       <= next_idx(idx);
      out_data  <= res_buf[next_idx(idx)];
      out_last  <= (next_idx(idx) == 2'd3);
    end
  end

endmodule

// File: rtl/elementwise_vec_stream_bridge.sv
// Serial operand loader, latency wait and FSM feeding the parallel multiplier; results
// are streamed back out through the result serializer.
module elementwise_vec_stream_bridge
  import elementwise_pkg::*;
#(
  parameter int N       = 8,
  parameter int LATENCY = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_a,
  input  logic [N-1:0]     in_b,
  output logic [N-1:0]     mul_a [0:LANES-1],
  output logic [N-1:0]     mul_b [0:LANES-1],
  input  logic [2*N-1:0]   mul_result [0:LANES-1],
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*N-1:0]   out_data,
  output logic             out_last,
  output logic             busy,
  output logic [7:0]       vec_count
);

  state_t     state;
  state_t     state_nxt;
  logic [1:0] idx;
  logic [2:0] wait_cnt;
  logic       accept;
  logic       load;
  logic       done;

  assign accept = in_valid & in_ready;
  // The final WAIT cycle covers the operand register plus LATENCY multiplier stages.
  assign load   = (state == WAIT) && (wait_cnt == 3'(LATENCY));

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      LOAD: begin
        if (accept && (idx == 2'd3)) state_nxt = WAIT;
        else                         state_nxt = LOAD;
      end
      WAIT: begin
        if (load) state_nxt = DRAIN;
        else      state_nxt = WAIT;
      end
      DRAIN: begin
        if (done) state_nxt = LOAD;
        else      state_nxt = DRAIN;
      end
      default: state_nxt = LOAD;
    endcase
  end

  // State register with handshake/status flags registered off the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= LOAD;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
      wait_cnt  <= 3'd0;
      vec_count <= 8'd0;
    end else begin
      state    <= state_nxt;
      in_ready <= (state_nxt == LOAD);
      busy     <= (state_nxt != LOAD);
      if (state == WAIT) wait_cnt <= wait_cnt + 3'd1;
      else               wait_cnt <= 3'd0;
      if (done) vec_count <= vec_count + 8'd1;
    end
  end

  // Operand lanes are written in place as pairs arrive.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LANES; i++) begin
        mul_a[i] <= '0;
        mul_b[i] <= '0;
      end
      idx <= 2'd0;
    end else if (accept) begin
      mul_a[idx] <= in_a;
      mul_b[idx] <= in_b;
      idx        <= next_idx(idx);
    end
  end

  elementwise_result_serializer #(.N(N)) u_ser (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .result    (mul_result),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_data  (out_data),
    .done      (done)
  );

endmodule

// File: tb/tb_elementwise_vec_stream_bridge.sv
// Self-checking bench: randomized vectors against a queue-based product model, with
// delay-line multiplier models for LATENCY=1 (main DUT) and LATENCY=3 (second DUT).
module tb_elementwise_vec_stream_bridge;

  logic        clk = 1'b0;
  logic        rst;

  logic        in_valid, in_ready, out_valid, out_ready, out_last, busy;
  logic [7:0]  in_a, in_b, vec_count;
  logic [7:0]  mul_a [0:3];
  logic [7:0]  mul_b [0:3];
  logic [15:0] mul_result [0:3];
  logic [15:0] out_data;

  logic        in_valid1, in_ready1, out_valid1, out_ready1, out_last1, busy1;
  logic [7:0]  in_a1, in_b1, vec_count1;
  logic [7:0]  mul_a1 [0:3];
  logic [7:0]  mul_b1 [0:3];
  logic [15:0] mul_result1 [0:3];
  logic [15:0] out_data1;
  logic [15:0] pipe1 [0:2][0:3];

  int          n_checks = 0;
  int          n_fail = 0;
  logic [15:0] exp_q [$];
  int          pos = 0;
  logic [7:0]  exp_vec = 8'd0;
  int          dut_last_cnt = 0;
  logic        hold_v = 1'b0;
  logic [15:0] hold_d = 16'd0;
  logic        rand_bp = 1'b0;
  logic [7:0]  va [0:3];
  logic [7:0]  vb [0:3];

  always #5 clk = ~clk;

  elementwise_vec_stream_bridge #(.N(8), .LATENCY(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .mul_a(mul_a), .mul_b(mul_b), .mul_result(mul_result), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_last(out_last), .busy(busy),
    .vec_count(vec_count)
  );

  elementwise_vec_stream_bridge #(.N(8), .LATENCY(3)) dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1), .in_a(in_a1), .in_b(in_b1),
    .mul_a(mul_a1), .mul_b(mul_b1), .mul_result(mul_result1), .out_valid(out_valid1),
    .out_ready(out_ready1), .out_data(out_data1), .out_last(out_last1), .busy(busy1),
    .vec_count(vec_count1)
  );

  // Multiplier models: one register stage for LATENCY=1, three for LATENCY=3.
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      mul_result[i] <= 16'(mul_a[i]) * 16'(mul_b[i]);
      pipe1[0][i]   <= 16'(mul_a1[i]) * 16'(mul_b1[i]);
      pipe1[1][i]   <= pipe1[0][i];
      pipe1[2][i]   <= pipe1[1][i];
    end
  end
  always_comb for (int i = 0; i < 4; i++) mul_result1[i] = pipe1[2][i];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_bp) out_ready = 1'($urandom_range(0, 1));
  endtask

  // Output scoreboard: every delivered product must match the model queue in order.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      pos = 0;
      exp_vec = 8'd0;
      hold_v = 1'b0;
    end else begin
      check_eq("vec_count", vec_count, exp_vec);
      if (hold_v) begin
        check_eq("bp_valid", out_valid, 1);
        check_eq("bp_hold", out_data, hold_d);
      end
      if (out_valid) begin
        check_eq("in_ready_drain", in_ready, 0);
        if (exp_q.size() == 0) check_eq("spurious_out", 1, 0);
        else begin
          check_eq("out_data", out_data, exp_q[0]);
          check_eq("out_last", out_last, (pos == 3) ? 1 : 0);
        end
        if (out_ready) begin
          if (exp_q.size() != 0) void'(exp_q.pop_front());
          if (out_last) dut_last_cnt++;
          if (pos == 3) begin
            pos = 0;
            exp_vec = exp_vec + 8'd1;
          end else pos++;
        end
      end else begin
        check_eq("last_idle", out_last, 0);
      end
      hold_v = out_valid & ~out_ready;
      hold_d = out_data;
    end
  end

  task automatic send_pair(input logic [7:0] a, input logic [7:0] b);
    int n = 0;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    while (!in_ready && n < 500) begin
      tick();
      n++;
    end
    if (n >= 500) check_eq("in_ready_timeout", 0, 1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic send_vec(input bit gaps);
    for (int i = 0; i < 4; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) tick();
      send_pair(va[i], vb[i]);
    end
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(16'(va[i]) * 16'(vb[i]));
      check_eq("lane_a", mul_a[i], va[i]);
      check_eq("lane_b", mul_b[i], vb[i]);
    end
    check_eq("wait_busy", busy, 1);
  endtask

  task automatic rand_vec();
    for (int i = 0; i < 4; i++) begin
      va[i] = 8'($urandom_range(0, 255));
      vb[i] = 8'($urandom_range(0, 255));
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || exp_q.size() != 0) && n < 2000) begin
      tick();
      n++;
    end
    if (n >= 2000) check_eq("drain_timeout", 0, 1);
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    #1;
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_last", out_last, 0);
    check_eq("rst_out_data", out_data, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_vec_count", vec_count, 0);
    for (int i = 0; i < 4; i++) begin
      check_eq("rst_mul_a", mul_a[i], 0);
      check_eq("rst_mul_b", mul_b[i], 0);
    end
    @(negedge clk);
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int cyc;
    bit pat [0:6];
    int k;
    rst = 1'b1;
    in_valid = 1'b0; in_a = 8'd0; in_b = 8'd0; out_ready = 1'b1;
    in_valid1 = 1'b0; in_a1 = 8'd0; in_b1 = 8'd0; out_ready1 = 1'b1;
    tick();
    reset_pulse();

    // Basic flow with the first-valid latency measured from the 4th accept edge.
    va = '{8'd3, 8'd5, 8'd7, 8'd255};
    vb = '{8'd2, 8'd4, 8'd6, 8'd255};
    send_vec(1'b0);
    cyc = 0;
    while (!out_valid && cyc < 50) begin
      tick();
      cyc++;
    end
    check_eq("latency1", cyc, 2);
    wait_idle();
    check_eq("basic_vec_count", vec_count, 1);

    // Input gaps 1,0,0,1,1,0,1.
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    rand_vec();
    k = 0;
    for (int c = 0; c < 7; c++) begin
      check_eq("gap_ready", in_ready, 1);
      in_valid = pat[c];
      in_a = va[k];
      in_b = vb[k];
      tick();
      if (pat[c]) k++;
    end
    in_valid = 1'b0;
    check_eq("gap_ready_low", in_ready, 0);
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(16'(va[i]) * 16'(vb[i]));
      check_eq("gap_lane_a", mul_a[i], va[i]);
    end
    wait_idle();

    // Backpressure for 5 cycles on element 1.
    va = '{8'd3, 8'd5, 8'd7, 8'd255};
    vb = '{8'd2, 8'd4, 8'd6, 8'd255};
    send_vec(1'b0);
    cyc = 0;
    while (!out_valid && cyc < 50) begin
      tick();
      cyc++;
    end
    tick();
    out_ready = 1'b0;
    repeat (5) begin
      check_eq("bp_elem1", out_data, 20);
      check_eq("bp_in_ready", in_ready, 0);
      tick();
    end
    out_ready = 1'b1;
    wait_idle();

    // Reset after 2 accepts, then in DRAIN at idx 2.
    send_pair(8'd11, 8'd12);
    send_pair(8'd13, 8'd14);
    reset_pulse();
    rand_vec();
    send_vec(1'b0);
    cyc = 0;
    while (!out_valid && cyc < 50) begin
      tick();
      cyc++;
    end
    tick();
    tick();
    reset_pulse();
    va = '{8'd1, 8'd1, 8'd1, 8'd1};
    vb = '{8'd9, 8'd8, 8'd7, 8'd6};
    send_pair(va[0], vb[0]);
    check_eq("post_rst_lane0", mul_b[0], 9);
    for (int i = 1; i < 4; i++) send_pair(va[i], vb[i]);
    for (int i = 0; i < 4; i++) exp_q.push_back(16'(va[i]) * 16'(vb[i]));
    wait_idle();
    check_eq("post_rst_vec_count", vec_count, 1);

    // Randomized traffic with gaps and random backpressure, then the 256-vector wrap.
    rand_bp = 1'b1;
    repeat (20) begin
      rand_vec();
      send_vec(1'b1);
    end
    wait_idle();
    rand_bp = 1'b0;
    out_ready = 1'b1;
    reset_pulse();
    k = dut_last_cnt;
    rand_bp = 1'b1;
    repeat (256) begin
      rand_vec();
      send_vec(1'b1);
    end
    wait_idle();
    rand_bp = 1'b0;
    out_ready = 1'b1;
    check_eq("wrap_last_pulses", dut_last_cnt - k, 256);
    check_eq("wrap_vec_count", vec_count, 0);

    // LATENCY=3 instance: first out_valid 4 cycles after the 4th accept.
    rand_vec();
    for (int i = 0; i < 4; i++) begin
      check_eq("l3_ready", in_ready1, 1);
      in_valid1 = 1'b1;
      in_a1 = va[i];
      in_b1 = vb[i];
      tick();
    end
    in_valid1 = 1'b0;
    cyc = 0;
    while (!out_valid1 && cyc < 50) begin
      tick();
      cyc++;
    end
    check_eq("latency3", cyc, 4);
    for (int i = 0; i < 4; i++) begin
      check_eq("l3_valid", out_valid1, 1);
      check_eq("l3_data", out_data1, 16'(va[i]) * 16'(vb[i]));
      check_eq("l3_last", out_last1, (i == 3) ? 1 : 0);
      tick();
    end
    check_eq("l3_vec_count", vec_count1, 1);
    check_eq("l3_idle", busy1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
